nco_phase_detector: RTL and testbench
=====================================

# nco_phase_detector

Inverse of the NCO datapath: it accepts quadrature sample pairs (sine, cosine), as produced by the NCO's `fsin_o`/`fcos_o`/`out_valid` interface or by a downstream mixer. An iterative CORDIC in vectoring mode converts each pair to an absolute phase word in the same format as the NCO phase accumulator. It also outputs a frequency word, the phase difference between consecutive samples, in the same format as `phi_inc_i`. The block sits after the NCO or mixer in the receive path and closes the loop for carrier/frequency tracking.

## Interface
- `mpr`, 18: width of the signed two's-complement sine/cosine inputs.
- `apr`, 32: width of the phase and frequency words. A full turn is 2^apr. Legal range 16..32.
- `iters`, 16: number of CORDIC micro-rotations. Legal range 8..24.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `clken`  in  1  clock enable. When low, every register holds its value.
- `in_valid`  in  1  input pair is valid.
- `in_ready`  out  1  block can accept a pair.
- `fsin_i`  in  mpr  signed sine (imaginary, y) component.
- `fcos_i`  in  mpr  signed cosine (real, x) component.
- `phi_o`  out  apr  phase of the accepted pair, unsigned fraction of a turn.
- `phi_inc_o`  out  apr  `phi_o` minus the previous `phi_o`, modulo 2^apr.
- `mag_o`  out  mpr+2  magnitude scaled by the CORDIC gain (≈1.6468).
- `out_valid`  out  1  results valid.

## Operation
- **FSM states:** IDLE, PREROT, ITER, DONE. All transitions are qualified by `clken`.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid`&&`clken`: sign-extend `fcos_i`→x and `fsin_i`→y to mpr+2 bits, go to PREROT.
  - `in_valid` while not in IDLE is ignored. Nothing is queued.
- **PREROT:**
  - If x<0: negate x and y, set z=2^(apr-1). Otherwise z=0.
  - Record a zero flag if x==0 && y==0.
  - Clear the iteration counter k. Go to ITER.
- **ITER (one micro-rotation per enabled cycle):**
  - If y≥0: x←x+(y>>>k), y←y−(x>>>k), z←z+atan_k.
  - Else: x←x−(y>>>k), y←y+(x>>>k), z←z−atan_k.
  - Shifts are arithmetic and use the pre-update x and y.
  - atan_k = round(atan(2^-k)/(2π)·2^apr), a constant table of 24 entries truncated to `iters`.
  - z arithmetic wraps modulo 2^apr.
  - After k = iters−1, go to DONE.
- **DONE:**
  - `out_valid`=1.
  - `phi_o`=z, `mag_o`=x. If the zero flag is set, both are forced to 0.
  - `phi_inc_o`=z−prev (mod 2^apr), then prev←`phi_o`.
  - Return to IDLE on the next enabled cycle.
- **Width rules:**
  - mpr+2 bits absorb the CORDIC gain without overflow for full-scale inputs, including (−2^(mpr−1), −2^(mpr−1)).
  - `mag_o` is always non-negative.
- **Reset (asynchronous):** state=IDLE, `in_ready`=1, `out_valid`=0, `phi_o`=0, `phi_inc_o`=0, `mag_o`=0, prev=0, x=y=z=k=0.
- **Reset mid-operation:** the in-flight pair is discarded and no `out_valid` is produced.
- **First result after reset:** `phi_inc_o` equals `phi_o`, because prev=0.

## Timing
- **Accept:** a pair is accepted on a rising edge where state=IDLE and `in_valid`&&`clken`.
- **Latency:** `out_valid` rises iters+2 enabled cycles after the accept edge (PREROT 1 cycle, ITER `iters` cycles, then DONE).
- **Output hold:** outputs are registered and stable while `out_valid`=1. They hold their value after `out_valid` falls until the next DONE.
- **Throughput:** one pair per iters+3 enabled cycles. `in_ready` is high only in IDLE.
- **Stall:** with `clken` low in DONE, `out_valid` stays high. Consumers qualify `out_valid` with `clken`.
- **Accuracy:** |`phi_o` error| ≤ 2^(apr−15) LSB for inputs with magnitude ≥ 2^(mpr−4), at default parameters.

## Test plan
- **Reset:** assert `reset` asynchronously mid-ITER → all outputs 0 immediately, `in_ready`=1. The next accepted pair gives `out_valid` exactly 18 cycles later (iters=16).
- **Axis points** (default parameters, tolerance ±2^17 LSB):
  - (cos,sin)=(+65536,0) → `phi_o`≈0x00000000.
  - (0,+65536) → `phi_o`≈0x40000000.
  - (−65536,0) → `phi_o`≈0x80000000.
  - (0,−65536) → `phi_o`≈0xC0000000.
  - `mag_o`≈107925 in each case.
- **Zero input:** (0,0) → `phi_o`=0, `mag_o`=0, `out_valid` pulses normally.
- **NCO loopback:** drive pairs from an NCO model with `phi_inc_i`=0x01000000 → from the second result onward, `phi_inc_o`=0x01000000 ±2^17. Wraparound past 0xFFFFFFFF gives no glitch in `phi_inc_o`.
- **Handshake:** hold `in_valid`=1 continuously with changing data → only pairs present when `in_ready`=1 are processed, one result per 19 cycles.
- **clken stall:** drop `clken` for 5 cycles during ITER and again during DONE → latency extends by exactly 5 enabled-cycle-equivalents each time, results are bit-identical to the unstalled run, and `out_valid` is held high through the DONE stall.

Source files
------------

// File: rtl/nco_phase_detector_if.sv
// ---------------------------------------------------------------------------
// nco_phase_detector_if
//
// Purpose:
//   Bundles the sample handshake and the result bus of nco_phase_detector.
//   The producer of quadrature samples uses the master modport. The phase
//   detector itself uses the slave modport.
//
// Signals:
//   in_valid   producer -> detector   sample pair is valid
//   in_ready   detector -> producer   detector can take a pair (IDLE only)
//   fsin_i     producer -> detector   signed sine (y) component, mpr bits
//   fcos_i     producer -> detector   signed cosine (x) component, mpr bits
//   phi_o      detector -> consumer   absolute phase, fraction of a turn
//   phi_inc_o  detector -> consumer   phase step since the previous result
//   mag_o      detector -> consumer   magnitude times the CORDIC gain
//   out_valid  detector -> consumer   results valid
// ---------------------------------------------------------------------------
interface nco_phase_detector_if #(
    parameter int mpr = 18,
    parameter int apr = 32
);

    logic                  in_valid;
    logic                  in_ready;
    logic signed [mpr-1:0] fsin_i;
    logic signed [mpr-1:0] fcos_i;
    logic        [apr-1:0] phi_o;
    logic        [apr-1:0] phi_inc_o;
    logic        [mpr+1:0] mag_o;
    logic                  out_valid;

    modport master (
        output in_valid,
        output fsin_i,
        output fcos_i,
        input  in_ready,
        input  phi_o,
        input  phi_inc_o,
        input  mag_o,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  fsin_i,
        input  fcos_i,
        output in_ready,
        output phi_o,
        output phi_inc_o,
        output mag_o,
        output out_valid
    );

endinterface

// File: rtl/nco_phase_detector.sv
// ---------------------------------------------------------------------------
// nco_phase_detector
//
// Purpose:
//   Converts a quadrature sample pair (sine, cosine) into an absolute phase
//   word in NCO phase-accumulator format, using an iterative CORDIC in
//   vectoring mode (one micro-rotation per enabled clock). It also reports
//   the phase step between consecutive results, in NCO phase-increment
//   format, and the vector magnitude scaled by the CORDIC gain.
//
// Parameters:
//   mpr    width of the signed sine/cosine inputs
//   apr    width of phase and frequency words (full turn = 2^apr), 16..32
//   iters  number of CORDIC micro-rotations, 8..24
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high reset
//   clken  clock enable; when low every register holds its value
//   bus    slave side of nco_phase_detector_if (handshake + results)
//
// Timing:
//   A pair is accepted on an enabled edge in IDLE. One cycle of
//   pre-rotation and iters cycles of micro-rotation follow; the results are
//   registered on the last micro-rotation edge, so out_valid is high during
//   the DONE cycle and the block is back in IDLE one enabled cycle later.
// ---------------------------------------------------------------------------
module nco_phase_detector #(
    parameter int mpr   = 18,
    parameter int apr   = 32,
    parameter int iters = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clken,
    nco_phase_detector_if.slave  bus
);

    // Two guard bits absorb the CORDIC gain (about 1.65) on top of the
    // sqrt(2) growth of a full-scale diagonal input.
    localparam int W = mpr + 2;

    // The arctangent table is kept at 32-bit precision and rounded down to
    // apr bits when apr is narrower.
    localparam int          RND_SH  = (apr < 32) ? (31 - apr) : 0;
    localparam logic [32:0] RND_ADD = (apr < 32) ? (33'd1 << RND_SH) : 33'd0;

    localparam logic [apr-1:0] HALF_TURN = {1'b1, {(apr-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        PREROT,
        ITER,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic signed [W-1:0] x;
    logic signed [W-1:0] y;
    logic signed [W-1:0] x_sh;
    logic signed [W-1:0] y_sh;
    logic signed [W-1:0] x_rot;
    logic signed [W-1:0] y_rot;
    logic [apr-1:0]      z;
    logic [apr-1:0]      z_rot;
    logic [apr-1:0]      atan_k;
    logic [apr-1:0]      phi_val;
    logic [apr-1:0]      prev;
    logic [4:0]          k;
    logic                zero_flag;
    logic                last_iter;
    logic                accept;

    // atan(2^-idx) as a fraction of a turn, scaled to 2^32 and rounded,
    // then rescaled to apr bits.
    function automatic logic [apr-1:0] atan_entry(input logic [4:0] idx);
        logic [31:0] t32;
        t32 = 32'h0000_0000;
        case (idx)
            5'd0:    t32 = 32'h2000_0000;
            5'd1:    t32 = 32'h12E4_051E;
            5'd2:    t32 = 32'h09FB_385B;
            5'd3:    t32 = 32'h0511_11D4;
            5'd4:    t32 = 32'h028B_0D43;
            5'd5:    t32 = 32'h0145_D7E1;
            5'd6:    t32 = 32'h00A2_F61E;
            5'd7:    t32 = 32'h0051_7C55;
            5'd8:    t32 = 32'h0028_BE53;
            5'd9:    t32 = 32'h0014_5F2F;
            5'd10:   t32 = 32'h000A_2F98;
            5'd11:   t32 = 32'h0005_17CC;
            5'd12:   t32 = 32'h0002_8BE6;
            5'd13:   t32 = 32'h0001_45F3;
            5'd14:   t32 = 32'h0000_A2FA;
            5'd15:   t32 = 32'h0000_517D;
            5'd16:   t32 = 32'h0000_28BE;
            5'd17:   t32 = 32'h0000_145F;
            5'd18:   t32 = 32'h0000_0A30;
            5'd19:   t32 = 32'h0000_0518;
            5'd20:   t32 = 32'h0000_028C;
            5'd21:   t32 = 32'h0000_0146;
            5'd22:   t32 = 32'h0000_00A3;
            5'd23:   t32 = 32'h0000_0051;
            default: t32 = 32'h0000_0000;
        endcase
        return apr'(({1'b0, t32} + RND_ADD) >> (32 - apr));
    endfunction

    // State register. Every transition is already qualified by clken in the
    // next-state logic, so the register simply follows state_next.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode. in_ready is a pure decode of the
    // state register, so it is high in IDLE and straight out of reset.
    // Pairs offered outside IDLE are simply not taken.
    always_comb begin
        state_next   = state;
        bus.in_ready = 1'b0;
        accept       = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid && clken) begin
                    accept     = 1'b1;
                    state_next = PREROT;
                end
            end
            PREROT: begin
                if (clken) begin
                    state_next = ITER;
                end
            end
            ITER: begin
                if (clken && last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (clken) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // One vectoring micro-rotation. The sign of y picks the rotation
    // direction that drives y toward zero; z accumulates the rotated angle
    // and wraps naturally modulo 2^apr. Both shifts use the pre-update x/y.
    always_comb begin
        last_iter = (k == 5'(iters - 1));
        atan_k    = atan_entry(k);
        x_sh      = x >>> k;
        y_sh      = y >>> k;
        x_rot     = x;
        y_rot     = y;
        z_rot     = z;
        if (!y[W-1]) begin
            x_rot = x + y_sh;
            y_rot = y - x_sh;
            z_rot = z + atan_k;
        end else begin
            x_rot = x - y_sh;
            y_rot = y + x_sh;
            z_rot = z - atan_k;
        end
        phi_val = zero_flag ? '0 : z_rot;
    end

    // CORDIC working registers. The pre-rotation folds the left half-plane
    // onto the right one (rotation by half a turn) so that the remaining
    // micro-rotations only need to cover about +/-100 degrees. A zero
    // vector has no defined angle, so it is flagged before rotation and its
    // outputs are forced to zero at the end.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x         <= '0;
            y         <= '0;
            z         <= '0;
            k         <= '0;
            zero_flag <= 1'b0;
        end else if (clken) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        x <= {{2{bus.fcos_i[mpr-1]}}, bus.fcos_i};
                        y <= {{2{bus.fsin_i[mpr-1]}}, bus.fsin_i};
                    end
                end
                PREROT: begin
                    if (x[W-1]) begin
                        x <= -x;
                        y <= -y;
                        z <= HALF_TURN;
                    end else begin
                        z <= '0;
                    end
                    zero_flag <= (x == '0) && (y == '0);
                    k         <= '0;
                end
                ITER: begin
                    x <= x_rot;
                    y <= y_rot;
                    z <= z_rot;
                    k <= k + 5'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Result registers. They load on the final micro-rotation edge so the
    // values are already stable for the whole DONE cycle, and they keep
    // their contents afterwards until the next result. The phase step is
    // taken against the previously reported phase, which is zero after
    // reset, so the first step equals the first phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.phi_o     <= '0;
            bus.phi_inc_o <= '0;
            bus.mag_o     <= '0;
            prev          <= '0;
        end else if (clken) begin
            if ((state == ITER) && last_iter) begin
                bus.out_valid <= 1'b1;
                bus.phi_o     <= phi_val;
                bus.phi_inc_o <= phi_val - prev;
                bus.mag_o     <= zero_flag ? '0 : $unsigned(x_rot);
                prev          <= phi_val;
            end else if (state == DONE) begin
                bus.out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nco_phase_detector.sv
// ---------------------------------------------------------------------------
// tb_nco_phase_detector
//
// Self-checking bench for nco_phase_detector at default parameters. The
// expected phase and magnitude come from floating-point atan2/sqrt of the
// applied integer pair; the expected phase step is the difference of two
// expected phases. Cycle numbering: the cycle right after the accept edge
// is cycle 1, so a result is expected to be visible in cycle iters+2.
// ---------------------------------------------------------------------------
module tb_nco_phase_detector;

    localparam int  MPR     = 18;
    localparam int  APR     = 32;
    localparam int  ITERS   = 16;
    localparam int  LAT     = ITERS + 2;
    localparam int  PERIOD  = ITERS + 3;
    localparam int  PHI_TOL = 1 << 17;
    localparam int  INC_TOL = 1 << 18;
    localparam int  MAG_TOL = 64;
    localparam real PI      = 3.14159265358979323846;
    localparam real TURN    = 4294967296.0;

    typedef struct {
        int          cos_v;
        int          sin_v;
        logic [31:0] exp_phi;
        int          exp_mag;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic clken;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] ref_prev;

    vec_t vectors [10];

    always #5 clk = ~clk;

    nco_phase_detector_if #(.mpr(MPR), .apr(APR)) bus ();

    nco_phase_detector #(
        .mpr   (MPR),
        .apr   (APR),
        .iters (ITERS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .clken (clken),
        .bus   (bus.slave)
    );

    // Expected phase: angle of (c, s) as an unsigned fraction of 2^32.
    function automatic logic [31:0] ref_phase(input int c, input int s);
        real    f;
        longint v;
        if (c == 0 && s == 0) return 32'h0;
        f = $atan2(real'(s), real'(c)) / (2.0 * PI);
        if (f < 0.0) f = f + 1.0;
        v = longint'(f * TURN);
        return v[31:0];
    endfunction

    // Expected magnitude: Euclidean length times the product of the
    // micro-rotation stretch factors.
    function automatic int ref_mag(input int c, input int s);
        real g;
        real p;
        g = 1.0;
        p = 1.0;
        for (int i = 0; i < ITERS; i++) begin
            g = g * $sqrt(1.0 + p);
            p = p / 4.0;
        end
        return int'(g * $sqrt(real'(c) * real'(c) + real'(s) * real'(s)));
    endfunction

    // Modular comparison with tolerance; tol = 0 means bit-exact.
    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected, input int tol);
        logic [31:0] d;
        longint      sd;
        n_checks++;
        d  = actual - expected;
        sd = longint'($signed(d));
        if (sd < 0) sd = -sd;
        if (sd > longint'(tol)) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h (tol %0d)",
                     name, actual, expected, tol);
        end
    endtask

    task automatic check_values(input string tag, input logic [31:0] phi,
                                input logic [31:0] inc, input logic [31:0] mag,
                                input logic [31:0] exp_phi, input int exp_mag,
                                input bit exact);
        check_output({tag, " phase"}, phi, exp_phi, exact ? 0 : PHI_TOL);
        check_output({tag, " magnitude"}, mag, exp_mag, exact ? 0 : MAG_TOL);
        check_output({tag, " phase step"}, inc, exp_phi - ref_prev, INC_TOL);
        ref_prev = exp_phi;
    endtask

    task automatic check_result(input string tag, input logic [31:0] phi,
                                input logic [31:0] inc, input logic [31:0] mag,
                                input int lat, input logic [31:0] exp_phi,
                                input int exp_mag, input bit exact);
        check_output({tag, " latency"}, lat, LAT, 0);
        check_values(tag, phi, inc, mag, exp_phi, exp_mag, exact);
    endtask

    // Offer one pair in IDLE, wait for its result (bounded), then step the
    // DUT back to IDLE. lat = 0 means no result arrived in time.
    task automatic apply_stimulus(input int c, input int s,
                                  output logic [31:0] phi,
                                  output logic [31:0] inc,
                                  output logic [31:0] mag, output int lat);
        bus.fcos_i   = MPR'(c);
        bus.fsin_i   = MPR'(s);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        for (int cyc = 2; cyc <= 60; cyc++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) begin
                lat = cyc;
                break;
            end
        end
        phi = bus.phi_o;
        inc = bus.phi_inc_o;
        mag = 32'(bus.mag_o);
        if (lat != 0) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic random_pair(output int c, output int s);
        real r;
        real a;
        r = real'($urandom_range(65536, 131071));
        a = 2.0 * PI * real'($urandom_range(0, 65535)) / 65536.0;
        c = int'(r * $cos(a));
        s = int'(r * $sin(a));
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] phi;
        logic [31:0] inc;
        logic [31:0] mag;
        logic [31:0] p;
        int          lat;
        int          c;
        int          s;
        int          cyc;
        int          highs;
        int          hc [PERIOD*3+18];
        int          hs [PERIOD*3+18];

        vectors[0] = '{ 65536,       0, 32'h0000_0000, 107922};
        vectors[1] = '{     0,   65536, 32'h4000_0000, 107922};
        vectors[2] = '{-65536,       0, 32'h8000_0000, 107922};
        vectors[3] = '{     0,  -65536, 32'hC000_0000, 107922};
        vectors[4] = '{     0,       0, 32'h0000_0000,      0};
        vectors[5] = '{ 46341,   46341, 32'h2000_0000, 107922};
        vectors[6] = '{-46341,  -46341, 32'hA000_0000, 107922};
        vectors[7] = '{-131072,-131072, 32'hA000_0000, 305250};
        vectors[8] = '{131071,       0, 32'h0000_0000, 215843};
        vectors[9] = '{-131072,      0, 32'h8000_0000, 215844};

        reset        = 1'b1;
        clken        = 1'b1;
        bus.in_valid = 1'b0;
        bus.fcos_i   = '0;
        bus.fsin_i   = '0;
        ref_prev     = 32'h0;

        repeat (3) @(posedge clk);
        #1;
        check_output("reset in_ready", 32'(bus.in_ready), 32'd1, 0);
        check_output("reset out_valid", 32'(bus.out_valid), 32'd0, 0);
        check_output("reset phi", bus.phi_o, 32'h0, 0);
        check_output("reset phi_inc", bus.phi_inc_o, 32'h0, 0);
        check_output("reset mag", 32'(bus.mag_o), 32'h0, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Axis points, diagonals, zero vector and full-scale corners.
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(vectors[i].cos_v, vectors[i].sin_v, phi, inc, mag, lat);
            check_result($sformatf("table %0d", i), phi, inc, mag, lat,
                         vectors[i].exp_phi, vectors[i].exp_mag,
                         (vectors[i].cos_v == 0) && (vectors[i].sin_v == 0));
        end

        // Random pairs of substantial magnitude anywhere on the circle.
        for (int i = 0; i < 24; i++) begin
            random_pair(c, s);
            apply_stimulus(c, s, phi, inc, mag, lat);
            check_result($sformatf("random %0d", i), phi, inc, mag, lat,
                         ref_phase(c, s), ref_mag(c, s), 1'b0);
        end

        // NCO loopback across the 2^32 wrap point.
        p = 32'hF800_0000;
        for (int n = 0; n < 20; n++) begin
            c = int'(100000.0 * $cos(2.0 * PI * real'(longint'(p)) / TURN));
            s = int'(100000.0 * $sin(2.0 * PI * real'(longint'(p)) / TURN));
            apply_stimulus(c, s, phi, inc, mag, lat);
            check_result($sformatf("loopback %0d", n), phi, inc, mag, lat,
                         ref_phase(c, s), ref_mag(c, s), 1'b0);
            if (n >= 1) begin
                check_output($sformatf("loopback %0d increment", n), inc,
                             32'h0100_0000, PHI_TOL);
            end
            p = p + 32'h0100_0000;
        end

        // in_valid held high with new data every cycle: only the pairs on
        // the cycles where the DUT sits in IDLE (every PERIOD cycles) count.
        for (int t = 0; t < PERIOD*3+18; t++) begin
            random_pair(hc[t], hs[t]);
        end
        highs = 0;
        bus.in_valid = 1'b1;
        for (int t = 0; t < PERIOD*3+18; t++) begin
            bus.fcos_i = MPR'(hc[t]);
            bus.fsin_i = MPR'(hs[t]);
            @(posedge clk);
            #1;
            if (bus.out_valid) highs++;
            if ((t % PERIOD) == LAT - 1) begin
                check_output($sformatf("handshake %0d valid", t / PERIOD),
                             32'(bus.out_valid), 32'd1, 0);
                check_values($sformatf("handshake %0d", t / PERIOD),
                             bus.phi_o, bus.phi_inc_o, 32'(bus.mag_o),
                             ref_phase(hc[t-LAT+1], hs[t-LAT+1]),
                             ref_mag(hc[t-LAT+1], hs[t-LAT+1]), 1'b0);
            end
        end
        bus.in_valid = 1'b0;
        check_output("handshake result count", highs, 4, 0);
        @(posedge clk);
        #1;

        // clken low for 5 cycles in ITER, then for 5 cycles in DONE.
        c = 70000;
        s = -50000;
        bus.fcos_i   = MPR'(c);
        bus.fsin_i   = MPR'(s);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        cyc = 1;
        lat = 0;
        for (int e = 0; e < 60; e++) begin
            if (cyc == 6) clken = 1'b0;
            if (cyc == 11) clken = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
            if (bus.out_valid) begin
                lat = cyc;
                break;
            end
        end
        check_output("iter stall latency", lat, LAT + 5, 0);
        check_values("iter stall", bus.phi_o, bus.phi_inc_o, 32'(bus.mag_o),
                     ref_phase(c, s), ref_mag(c, s), 1'b0);
        clken = 1'b0;
        for (int e = 0; e < 5; e++) begin
            @(posedge clk);
            #1;
            check_output($sformatf("done stall %0d valid", e),
                         32'(bus.out_valid), 32'd1, 0);
            check_output($sformatf("done stall %0d phase", e), bus.phi_o,
                         ref_phase(c, s), PHI_TOL);
        end
        clken = 1'b1;
        @(posedge clk);
        #1;
        check_output("done stall release", 32'(bus.out_valid), 32'd0, 0);
        check_output("done stall in_ready", 32'(bus.in_ready), 32'd1, 0);

        // Asynchronous reset in the middle of ITER.
        bus.fcos_i   = MPR'(40000);
        bus.fsin_i   = MPR'(90000);
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_output("midreset out_valid", 32'(bus.out_valid), 32'd0, 0);
        check_output("midreset in_ready", 32'(bus.in_ready), 32'd1, 0);
        check_output("midreset phi", bus.phi_o, 32'h0, 0);
        check_output("midreset phi_inc", bus.phi_inc_o, 32'h0, 0);
        check_output("midreset mag", 32'(bus.mag_o), 32'h0, 0);
        ref_prev = 32'h0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        apply_stimulus(-70000, 30000, phi, inc, mag, lat);
        check_result("after reset", phi, inc, mag, lat,
                     ref_phase(-70000, 30000), ref_mag(-70000, 30000), 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
